hazard_unit_mc: RTL and testbench

Next-generation hazard and forwarding unit for the 5-stage RV32 pipeline.
- Adds a multi-cycle execute path (iterative MUL/DIV) with a BUSY FSM that holds F/D/E and bubbles M.
- Keeps load-use stall, branch/jump redirect flush and M/W-to-E forwarding.
- Adds parametrised register-address width, latency and load encoding, plus optional stall/flush performance counters.

---
 rtl/hazard_unit_mc.sv | 90 +++++++++
 tb/tb_hazard_unit_mc.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/hazard_unit_mc.sv
// hazard_unit_mc: RV32 5-stage hazard/forwarding unit with a multi-cycle EX hold FSM.
// Optional HAZARD_PERF_EN adds the saturating StallCnt/FlushCnt outputs.
// Ports: clk/reset; D sources rs1D/rs2D; E info rdE/ResultSrcE/PCSrcE/McStartE/rs1E/rs2E;
// M/W writeback rdM/rdW/RegWriteM/RegWriteW; out Stall{F,D,E}, Flush{D,E,M}, Forward{A,B}E, McBusy, McDoneE.
module hazard_unit_mc #(
  parameter int          REG_AW    = 5,
  parameter int          MC_LAT    = 4,
  parameter logic [1:0]  RSRC_LOAD = 2'b01
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [REG_AW-1:0] rs1D,
  input  logic [REG_AW-1:0] rs2D,
  input  logic [REG_AW-1:0] rdE,
  input  logic [1:0]        ResultSrcE,
  input  logic              PCSrcE,
  input  logic              McStartE,
  input  logic [REG_AW-1:0] rs1E,
  input  logic [REG_AW-1:0] rs2E,
  input  logic [REG_AW-1:0] rdM,
  input  logic [REG_AW-1:0] rdW,
  input  logic              RegWriteM,
  input  logic              RegWriteW,
  output logic              StallF,
  output logic              StallD,
  output logic              StallE,
  output logic              FlushD,
  output logic              FlushE,
  output logic              FlushM,
  output logic [1:0]        ForwardAE,
  output logic [1:0]        ForwardBE,
  output logic              McBusy,
  output logic              McDoneE
`ifdef HAZARD_PERF_EN
  ,
  output logic [31:0]       StallCnt,
  output logic [31:0]       FlushCnt
`endif
);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic       mc_hold, lw_stall;
  // BUSY lasts MC_LAT-2 cycles: cnt starts at MC_LAT-2 and DONE follows the cycle cnt reads 1.
  always_comb begin
    mc_hold   = (state_q == IDLE && McStartE) || state_q == BUSY;
    lw_stall  = ResultSrcE == RSRC_LOAD && rdE != '0 && (rdE == rs1D || rdE == rs2D);
    state_d   = state_q == IDLE ? (McStartE ? (MC_LAT <= 2 ? DONE : BUSY) : IDLE)
              : state_q == BUSY ? (cnt_q <= 8'd1 ? DONE : BUSY) : IDLE;
    cnt_d     = (state_q == IDLE && McStartE) ? 8'(MC_LAT - 2)
              : state_q == BUSY ? cnt_q - 8'd1 : cnt_q;
    StallF    = lw_stall | mc_hold;
    StallD    = lw_stall | mc_hold;
    StallE    = mc_hold;
    FlushM    = mc_hold;
    FlushD    = PCSrcE & ~mc_hold;
    FlushE    = (lw_stall | PCSrcE) & ~mc_hold;
    McBusy    = state_q == BUSY;
    McDoneE   = state_q == DONE;
    ForwardAE = (RegWriteM && rdM != '0 && rdM == rs1E) ? 2'b10
              : (RegWriteW && rdW != '0 && rdW == rs1E) ? 2'b01 : 2'b00;
    ForwardBE = (RegWriteM && rdM != '0 && rdM == rs2E) ? 2'b10
              : (RegWriteW && rdW != '0 && rdW == rs2E) ? 2'b01 : 2'b00;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
`ifdef HAZARD_PERF_EN
  logic [31:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;
  always_comb begin
    stall_cnt_d = (StallF && ~&stall_cnt_q) ? stall_cnt_q + 32'd1 : stall_cnt_q;
    flush_cnt_d = ((FlushD | FlushE) && ~&flush_cnt_q) ? flush_cnt_q + 32'd1 : flush_cnt_q;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  assign StallCnt = stall_cnt_q;
  assign FlushCnt = flush_cnt_q;
`endif
endmodule

// File: tb/tb_hazard_unit_mc.sv
// tb_hazard_unit_mc: directed plus random stimulus against a cycle-position reference model.
module tb_hazard_unit_mc;
  localparam int         AW     = 5;
  localparam int         LAT    = 4;
  localparam logic [1:0] LOADRS = 2'b01;
  logic clk = 1'b0, reset = 1'b1;
  logic [AW-1:0] rs1D = '0, rs2D = '0, rdE = '0, rs1E = '0, rs2E = '0, rdM = '0, rdW = '0;
  logic [1:0] ResultSrcE = '0;
  logic PCSrcE = 0, McStartE = 0, RegWriteM = 0, RegWriteW = 0;
  logic StallF, StallD, StallE, FlushD, FlushE, FlushM, McBusy, McDoneE;
  logic [1:0] ForwardAE, ForwardBE;
`ifdef HAZARD_PERF_EN
  logic [31:0] StallCnt, FlushCnt;
  longint exp_stall = 0, exp_flush = 0;
`endif
  int total = 0, bad = 0;
  bit in_op = 0;
  int pos = 0;
  always #5 clk = ~clk;
  hazard_unit_mc #(.REG_AW(AW), .MC_LAT(LAT), .RSRC_LOAD(LOADRS)) dut (
    .clk(clk), .reset(reset), .rs1D(rs1D), .rs2D(rs2D), .rdE(rdE), .ResultSrcE(ResultSrcE),
    .PCSrcE(PCSrcE), .McStartE(McStartE), .rs1E(rs1E), .rs2E(rs2E), .rdM(rdM), .rdW(rdW),
    .RegWriteM(RegWriteM), .RegWriteW(RegWriteW), .StallF(StallF), .StallD(StallD),
    .StallE(StallE), .FlushD(FlushD), .FlushE(FlushE), .FlushM(FlushM),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .McBusy(McBusy), .McDoneE(McDoneE)
`ifdef HAZARD_PERF_EN
    , .StallCnt(StallCnt), .FlushCnt(FlushCnt)
`endif
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask
  function automatic logic [1:0] fwd(input logic [AW-1:0] rs);
    if (RegWriteM && rdM != 0 && rdM == rs) return 2'b10;
    if (RegWriteW && rdW != 0 && rdW == rs) return 2'b01;
    return 2'b00;
  endfunction
  task automatic expect_now(output logic hold, output logic lw, output logic done, output logic busy);
    hold = in_op ? (pos < LAT - 1) : McStartE;
    done = in_op && pos == LAT - 1;
    busy = in_op && pos >= 1 && pos < LAT - 1;
    lw   = ResultSrcE == LOADRS && rdE != 0 && (rdE == rs1D || rdE == rs2D);
  endtask
  task automatic check_now();
    logic h, lw, d, b;
    expect_now(h, lw, d, b);
    chk("StallF", StallF, lw | h);
    chk("StallD", StallD, lw | h);
    chk("StallE", StallE, h);
    chk("FlushM", FlushM, h);
    chk("FlushD", FlushD, PCSrcE & ~h);
    chk("FlushE", FlushE, (lw | PCSrcE) & ~h);
    chk("McBusy", McBusy, b);
    chk("McDoneE", McDoneE, d);
    chk("ForwardAE", ForwardAE, fwd(rs1E));
    chk("ForwardBE", ForwardBE, fwd(rs2E));
`ifdef HAZARD_PERF_EN
    chk("StallCnt", StallCnt, exp_stall[31:0]);
    chk("FlushCnt", FlushCnt, exp_flush[31:0]);
`endif
  endtask
  task automatic step();
    logic h, lw, d, b;
    if (reset) in_op = 0;
    @(negedge clk);
    check_now();
    expect_now(h, lw, d, b);
    @(posedge clk);
    if (reset) begin
      in_op = 0;
`ifdef HAZARD_PERF_EN
      exp_stall = 0;
      exp_flush = 0;
`endif
    end else begin
`ifdef HAZARD_PERF_EN
      if ((lw | h) && exp_stall < 64'hFFFF_FFFF) exp_stall++;
      if (((PCSrcE & ~h) | ((lw | PCSrcE) & ~h)) && exp_flush < 64'hFFFF_FFFF) exp_flush++;
`endif
      if (in_op) begin
        pos++;
        if (pos == LAT) in_op = 0;
      end else if (McStartE) begin
        in_op = 1;
        pos = 1;
      end
    end
    #1;
  endtask
  task automatic zero_inputs();
    {rs1D, rs2D, rdE, rs1E, rs2E, rdM, rdW} = '0;
    ResultSrcE = '0;
    {PCSrcE, McStartE, RegWriteM, RegWriteW} = '0;
  endtask
  initial begin
    zero_inputs();
    reset = 1;
    step();
    step();
    reset = 0;
    step();
    rdE = 5; rs2D = 5; ResultSrcE = 2'b01;
    step();
    rdE = 0; rs2D = 0;
    step();
    zero_inputs();
    McStartE = 1;
    repeat (LAT) step();
    McStartE = 0;
    step();
    McStartE = 1;
    step();
    step();
    McStartE = 0;
    PCSrcE = 1;
    step();
    step();
    step();
    PCSrcE = 1; ResultSrcE = 2'b01; rdE = 9; rs1D = 9;
    step();
    zero_inputs();
    rdM = 7; rdW = 7; rs1E = 7; rs2E = 7; RegWriteM = 1; RegWriteW = 1;
    step();
    RegWriteM = 0;
    step();
    rs1E = 0; rs2E = 0;
    step();
    rs1E = 7; RegWriteM = 1; rdM = 3;
    step();
    zero_inputs();
    McStartE = 1;
    step();
    step();
    step();
    reset = 1;
    McStartE = 0;
    #1;
    in_op = 0;
    check_now();
    step();
    reset = 0;
    McStartE = 1;
    repeat (LAT) step();
    McStartE = 0;
    step();
    for (int i = 0; i < 400; i++) begin
      rs1D = AW'($urandom_range(0, 3)); rs2D = AW'($urandom_range(0, 3));
      rdE  = AW'($urandom_range(0, 3)); rs1E = AW'($urandom_range(0, 3));
      rs2E = AW'($urandom_range(0, 3)); rdM  = AW'($urandom_range(0, 3));
      rdW  = AW'($urandom_range(0, 3));
      ResultSrcE = 2'($urandom_range(0, 3));
      PCSrcE    = ($urandom_range(0, 3) == 0);
      McStartE  = ($urandom_range(0, 2) == 0);
      RegWriteM = 1'($urandom);
      RegWriteW = 1'($urandom);
      reset     = ($urandom_range(0, 49) == 0);
      step();
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
